// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int REGFILE_XLEN  = 32;
  localparam int REGFILE_NREGS = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/register_file_mp.sv
// Multi-port register file with per-register pending scoreboard and a bulk-clear FSM.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle accepted write to matching read ports.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = REGFILE_XLEN,
  parameter int NREGS = REGFILE_NREGS,
  parameter int NRD   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]     rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  input  logic                    iss_valid,
  input  logic [$clog2(NREGS)-1:0] iss_addr,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  state_e           state_q;
  state_e           state_d;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    idx_d;
  logic             wr_acc_s;

  assign clr_busy = (state_q == CLEAR);
  assign wr_ready = ~clr_busy;
  assign wr_acc_s = wr_valid & wr_ready & (wr_addr != '0);

  // Next-state for storage, scoreboard and clear sequencer
  always_comb begin
    mem_d   = mem_q;
    pend_d  = pend_q;
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (wr_acc_s) begin
          mem_d[wr_addr]  = wr_data;
          pend_d[wr_addr] = 1'b0;
        end else begin
          pend_d = pend_d;
        end
        // Issue is applied after the write so a same-address set wins.
        if (iss_valid && (iss_addr != '0)) begin
          pend_d[iss_addr] = 1'b1;
        end else begin
          pend_d = pend_d;
        end
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        mem_d[idx_q]  = '0;
        pend_d[idx_q] = 1'b0;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    mem_d[0]  = '0;
    pend_d[0] = 1'b0;
  end

  // State registers with asynchronous reset that also aborts any clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        mem_q[k] <= '0;
      end
      pend_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        mem_q[k] <= mem_d[k];
      end
      pend_q  <= pend_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] dat_s;
    logic            bsy_s;
    logic            hit_s;

    assign ra_s = rd_addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign hit_s = wr_acc_s & (ra_s == wr_addr);
`else
    assign hit_s = 1'b0;
`endif

    // Zero-latency read; address 0 is hard-wired to zero and never busy
    always_comb begin
      dat_s = '0;
      bsy_s = 1'b0;
      if (ra_s == '0) begin
        dat_s = '0;
        bsy_s = 1'b0;
      end else if (hit_s) begin
        dat_s = wr_data;
        bsy_s = 1'b0;
      end else begin
        dat_s = mem_q[ra_s];
        bsy_s = pend_q[ra_s];
      end
    end

    assign rd_data[g*XLEN +: XLEN] = dat_s;
    assign rd_busy[g]              = bsy_s;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with an expected-value scoreboard queue.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        clr_req;
  logic        clr_busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [32];

  register_file_mp dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h with empty scoreboard", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read0(input logic [4:0] a);
    rd_addr[4:0] = a;
    #1;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_addr = '0; clr_req = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    #12;
    rst = 1'b0;
    tick();

    // Reset state on two ports
    rd_addr = {5'd3, 5'd2};
    #1;
    expect_val(32'h0); check("rst_rd0", rd_data[31:0]);
    expect_val(32'h0); check("rst_rd1", rd_data[63:32]);
    expect_val(32'h0); check("rst_busy", {30'd0, rd_busy});
    expect_val(32'h1); check("rst_wr_ready", {31'd0, wr_ready});
    expect_val(32'h0); check("rst_clr_busy", {31'd0, clr_busy});

    // Basic write/read and x0 hard-wired
    do_write(5'd5, 32'hDEADBEEF);
    read0(5'd5);
    expect_val(32'hDEADBEEF); check("x5_data", rd_data[31:0]);
    rd_addr[9:5] = 5'd5; #1;
    expect_val(32'hDEADBEEF); check("x5_port1", rd_data[63:32]);
    do_write(5'd0, 32'h1234);
    read0(5'd0);
    expect_val(32'h0); check("x0_data", rd_data[31:0]);
    expect_val(32'h0); check("x0_busy", {31'd0, rd_busy[0]});

    // Scoreboard set, clear and set-wins collision
    iss_valid = 1'b1; iss_addr = 5'd7; tick(); iss_valid = 1'b0;
    read0(5'd7);
    expect_val(32'h1); check("x7_busy_iss", {31'd0, rd_busy[0]});
    do_write(5'd7, 32'd10);
    read0(5'd7);
    expect_val(32'h0); check("x7_busy_wr", {31'd0, rd_busy[0]});
    expect_val(32'd10); check("x7_data_wr", rd_data[31:0]);
    iss_valid = 1'b1; iss_addr = 5'd7;
    do_write(5'd7, 32'd20);
    iss_valid = 1'b0;
    read0(5'd7);
    expect_val(32'h1); check("x7_busy_both", {31'd0, rd_busy[0]});
    expect_val(32'd20); check("x7_data_both", rd_data[31:0]);

    // Same-cycle write visibility, with x9 pending beforehand
    do_write(5'd9, 32'h11);
    iss_valid = 1'b1; iss_addr = 5'd9; tick(); iss_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    read0(5'd9);
`ifdef REGFILE_BYPASS_EN
    expect_val(32'h55); expect_val(32'h0);
`else
    expect_val(32'h11); expect_val(32'h1);
`endif
    check("x9_same_cycle_data", rd_data[31:0]);
    check("x9_same_cycle_busy", {31'd0, rd_busy[0]});
    tick(); wr_valid = 1'b0; #1;
    expect_val(32'h55); check("x9_after_edge", rd_data[31:0]);
    expect_val(32'h0); check("x9_busy_after", {31'd0, rd_busy[0]});

    // Fill, then bulk clear with writes and issues held active
    for (int i = 1; i < 32; i++) begin
      mdl[i] = (32'(i) * 32'h01010101) ^ 32'hA5000000;
      do_write(5'(i), mdl[i]);
    end
    read0(5'd17);
    expect_val(mdl[17]); check("fill_x17", rd_data[31:0]);
    read0(5'd31);
    expect_val(mdl[31]); check("fill_x31", rd_data[31:0]);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF;
    iss_valid = 1'b1; iss_addr = 5'd4;
    expect_val(32'h0); check("clr_wr_ready", {31'd0, wr_ready});
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 2) begin
        read0(5'd1);
        expect_val(32'h0); check("clr_mid_x1", rd_data[31:0]);
        read0(5'd20);
        expect_val(mdl[20]); check("clr_mid_x20", rd_data[31:0]);
      end
      tick();
    end
    wr_valid = 1'b0; iss_valid = 1'b0;
    expect_val(32'd31); check("clr_cycles", 32'(cnt));
    for (int i = 0; i < 32; i++) begin
      read0(5'(i));
      expect_val({rd_busy[0] === 1'b0 ? 32'h0 : 32'h1} & 32'h0 | 32'h0);
      check($sformatf("clr_x%0d", i), rd_data[31:0] | {31'd0, rd_busy[0]});
    end

    // Reset in the middle of a clear
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hC0DE0000 | 32'(i));
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    read0(5'd20);
    expect_val(32'hC0DE0014); check("mid_clr_x20", rd_data[31:0]);
    expect_val(32'h1); check("mid_clr_busy", {31'd0, clr_busy});
    rst = 1'b1; #1;
    expect_val(32'h0); check("rst_abort_busy", {31'd0, clr_busy});
    expect_val(32'h1); check("rst_abort_ready", {31'd0, wr_ready});
    expect_val(32'h0); check("rst_abort_x20", rd_data[31:0]);
    tick(); rst = 1'b0; tick();
    for (int i = 1; i < 32; i += 6) begin
      read0(5'(i));
      expect_val(32'h0); check($sformatf("post_rst_x%0d", i), rd_data[31:0]);
    end
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    expect_val(32'h1); check("reclr_busy", {31'd0, clr_busy});
    cnt = 0;
    while (clr_busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    expect_val(32'd31); check("reclr_cycles", 32'(cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
